// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Watches a multiplexed, active-low 7-segment bus (anode selects plus segment
// lines) and recovers the hex digit shown at each position. A position's
// pattern is only captured after the (an, seg) pair has been seen unchanged
// for STABLE_CYCLES consecutive samples, which rejects scan transitions and
// ghosting.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   an_in        anode selects, active-low, one bit per position
//   seg_in       segment lines, active-low, bit6=a ... bit0=g
//   digits_out   recovered nibble per position, position i at [4i+3:4i]
//   digit_valid  last capture at position i was a legal hex pattern
//   digit_blank  last capture at position i was all segments off
//   update_pulse one-cycle strobe on every capture
//   update_index position of the capture (meaningful with update_pulse)
//   pattern_err  one-cycle strobe when a capture is neither legal nor blank
//   frame_done   one-cycle strobe when every position has been captured
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     an_in,
    input  logic [6:0]                seg_in,
    output logic [4*NUM_DIGITS-1:0]   digits_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     digit_blank,
    output logic                      update_pulse,
    output logic [2:0]                update_index,
    output logic                      pattern_err,
    output logic                      frame_done
);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [NUM_DIGITS-1:0]     an_s_reg;
    logic [6:0]                seg_s_reg;
    logic [NUM_DIGITS-1:0]     mask_reg, mask_next;
    logic [4*NUM_DIGITS-1:0]   digits_reg, digits_next;
    logic [NUM_DIGITS-1:0]     valid_reg, valid_next;
    logic [NUM_DIGITS-1:0]     blank_reg, blank_next;
    logic                      pulse_reg, err_reg, frame_reg;
    logic [2:0]                index_reg;

    logic [NUM_DIGITS-1:0]     sel;
    logic                      sel_valid;
    logic [2:0]                sel_idx;
    logic                      same;
    logic                      capture;
    logic                      legal;
    logic                      blank;
    logic [3:0]                nibble;
    logic [NUM_DIGITS-1:0]     hit;
    logic [NUM_DIGITS-1:0]     mask_or;
    logic                      frame_hit;

    // Inverse of the hex-to-segment table; bit 4 flags a legal pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0001100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    // The FSM acts on the pair being sampled this edge and compares it with
    // the pair sampled on the previous edge, so a pattern first presented
    // at edge k is captured at edge k+STABLE_CYCLES-1.
    always_comb begin
        sel       = ~an_in;
        sel_valid = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        sel_idx   = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) sel_idx = 3'(i);
        end
        same = (an_in == an_s_reg) && (seg_in == seg_s_reg);
        {legal, nibble} = decode(seg_in);
        blank = (seg_in == 7'h7F);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (!sel_valid) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = COUNT;
                    cnt_next   = CNT_W'(1);
                end
                COUNT: begin
                    if (!same) begin
                        cnt_next = CNT_W'(1);
                    end else if (cnt_reg + CNT_W'(1) == CNT_W'(STABLE_CYCLES)) begin
                        capture    = 1'b1;
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!same) begin
                        state_next = COUNT;
                        cnt_next   = CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Per-position capture: illegal and blank captures keep the old nibble.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            assign hit[gi] = capture && (sel_idx == 3'(gi));
            assign digits_next[4*gi +: 4] = (hit[gi] && legal) ? nibble
                                                              : digits_reg[4*gi +: 4];
            assign valid_next[gi] = hit[gi] ? legal : valid_reg[gi];
            assign blank_next[gi] = hit[gi] ? blank : blank_reg[gi];
        end
    endgenerate

    assign mask_or   = mask_reg | hit;
    assign frame_hit = capture && (&mask_or);
    assign mask_next = frame_hit ? '0 : mask_or;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            an_s_reg   <= '1;
            seg_s_reg  <= '0;
            mask_reg   <= '0;
            digits_reg <= '0;
            valid_reg  <= '0;
            blank_reg  <= '0;
            pulse_reg  <= 1'b0;
            err_reg    <= 1'b0;
            frame_reg  <= 1'b0;
            index_reg  <= 3'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            an_s_reg   <= an_in;
            seg_s_reg  <= seg_in;
            mask_reg   <= mask_next;
            digits_reg <= digits_next;
            valid_reg  <= valid_next;
            blank_reg  <= blank_next;
            pulse_reg  <= capture;
            err_reg    <= capture && !legal && !blank;
            frame_reg  <= frame_hit;
            if (capture) index_reg <= sel_idx;
        end
    end

    assign digits_out   = digits_reg;
    assign digit_valid  = valid_reg;
    assign digit_blank  = blank_reg;
    assign update_pulse = pulse_reg;
    assign update_index = index_reg;
    assign pattern_err  = err_reg;
    assign frame_done   = frame_reg;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NUM_DIGITS=4, STABLE_CYCLES=4).
// Stimulus pushes the expected capture into a queue; a monitor pops and
// compares whenever update_pulse is seen.
module tb_seg7_scan_reader;

    logic        clk;
    logic        rst;
    logic [3:0]  an_in;
    logic [6:0]  seg_in;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_blank;
    logic        update_pulse;
    logic [2:0]  update_index;
    logic        pattern_err;
    logic        frame_done;

    seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .an_in        (an_in),
        .seg_in       (seg_in),
        .digits_out   (digits_out),
        .digit_valid  (digit_valid),
        .digit_blank  (digit_blank),
        .update_pulse (update_pulse),
        .update_index (update_index),
        .pattern_err  (pattern_err),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    typedef struct {
        int          edge_n;
        logic [2:0]  idx;
        logic        err;
        logic        frame;
        logic [15:0] digits;
        logic [3:0]  dval;
        logic [3:0]  dblank;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_digits;
    logic [3:0]  exp_val;
    logic [3:0]  exp_blank;
    logic [6:0]  pat [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, ec);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        an_in  = a;
        seg_in = s;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 legal, 1 blank, 2 illegal. Capture lands 4 edges after drive.
    task automatic push(input int idx, input int kind, input logic [3:0] nib, input logic frame);
        exp_t e;
        case (kind)
            0: begin exp_digits[4*idx +: 4] = nib; exp_val[idx] = 1'b1; exp_blank[idx] = 1'b0; end
            1: begin exp_val[idx] = 1'b0; exp_blank[idx] = 1'b1; end
            default: begin exp_val[idx] = 1'b0; exp_blank[idx] = 1'b0; end
        endcase
        e.edge_n = ec + 4;
        e.idx    = 3'(idx);
        e.err    = (kind == 2);
        e.frame  = frame;
        e.digits = exp_digits;
        e.dval   = exp_val;
        e.dblank = exp_blank;
        sb_q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_digits"}, 32'(digits_out), 32'h0);
        chk({tag, "_valid"},  32'(digit_valid), 32'h0);
        chk({tag, "_blank"},  32'(digit_blank), 32'h0);
        chk({tag, "_strobes"}, {29'd0, update_pulse, pattern_err, frame_done}, 32'h0);
        chk({tag, "_index"},  32'(update_index), 32'h0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (update_pulse) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_update", 32'(update_index), 32'hFFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("capture idx=%0d digits=%h valid=%b blank=%b err=%b frame=%b edge=%0d",
                             update_index, digits_out, digit_valid, digit_blank,
                             pattern_err, frame_done, ec);
                    chk("cap_edge",   32'(ec), 32'(e.edge_n));
                    chk("cap_index",  32'(update_index), 32'(e.idx));
                    chk("cap_err",    32'(pattern_err), 32'(e.err));
                    chk("cap_frame",  32'(frame_done), 32'(e.frame));
                    chk("cap_digits", 32'(digits_out), 32'(e.digits));
                    chk("cap_valid",  32'(digit_valid), 32'(e.dval));
                    chk("cap_blank",  32'(digit_blank), 32'(e.dblank));
                end
            end else if (pattern_err || frame_done) begin
                chk("stray_strobe", {30'd0, pattern_err, frame_done}, 32'h0);
            end
        end
    end

    initial begin
        pat[0]  = 7'b0000001; pat[1]  = 7'b1001111; pat[2]  = 7'b0010010; pat[3]  = 7'b0000110;
        pat[4]  = 7'b1001100; pat[5]  = 7'b0100100; pat[6]  = 7'b0100000; pat[7]  = 7'b0001111;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0001100; pat[10] = 7'b0001000; pat[11] = 7'b1100000;
        pat[12] = 7'b0110001; pat[13] = 7'b1000010; pat[14] = 7'b0110000; pat[15] = 7'b0111000;
        exp_digits = '0; exp_val = '0; exp_blank = '0;

        rst = 1'b1;
        drive(4'b1111, 7'h7F);
        hold(3);
        check_reset("reset");
        rst = 1'b0;

        // Single stable digit, held beyond the capture: exactly one pulse.
        drive(4'b1110, 7'b0010010); push(0, 0, 4'h2, 1'b0); hold(6);

        // Short-lived 3 is rejected; F captured at position 1.
        drive(4'b1101, 7'b0000110); hold(3);
        drive(4'b1101, 7'b0111000); push(1, 0, 4'hF, 1'b0); hold(4);

        // Blank then illegal at position 2.
        drive(4'b1011, 7'b1111111); push(2, 1, 4'h0, 1'b0); hold(4);
        drive(4'b1011, 7'b1111110); push(2, 2, 4'h0, 1'b0); hold(4);

        // Invalid selects: nothing captured.
        drive(4'b1100, 7'b0101010); hold(10);
        drive(4'b1111, 7'b0000000); hold(10);

        // Full scan completes the frame on position 3.
        drive(4'b1110, 7'b1001111); push(0, 0, 4'h1, 1'b0); hold(5);
        drive(4'b1101, 7'b0001100); push(1, 0, 4'h9, 1'b0); hold(5);
        drive(4'b1011, 7'b0001000); push(2, 0, 4'hA, 1'b0); hold(5);
        drive(4'b0111, 7'b1000010); push(3, 0, 4'hD, 1'b1); hold(5);
        drive(4'b1110, 7'b1001111); push(0, 0, 4'h1, 1'b0); hold(5);

        // Reset in the middle of a count discards it.
        drive(4'b1110, 7'b0000001); hold(3);
        rst = 1'b1;
        hold(2);
        check_reset("midreset");
        exp_digits = '0; exp_val = '0; exp_blank = '0;
        rst = 1'b0;
        push(0, 0, 4'h0, 1'b0); hold(5);

        // Every legal pattern at position 1.
        for (int i = 0; i < 16; i++) begin
            drive(4'b1101, pat[i]); push(1, 0, 4'(i), 1'b0); hold(4);
        end

        drive(4'b1111, 7'h7F); hold(6);
        chk("queue_drain", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
Reads a multiplexed, active-low 7-segment display bus (anode select plus segment lines) and recovers the hex digit shown on each position. It is the inverse of the team's hex-to-segment decoder. It is used as an on-chip monitor and scoreboard tap for the display path, confirming the digits the game logic drives onto the board display. Each position's pattern is captured only after it has been stable for a programmable number of cycles, so scan transitions and ghosting are rejected.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255)
CNT_W, 8, stability counter width; STABLE_CYCLES must be < 2^CNT_W

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
an_in  input  NUM_DIGITS  anode selects, active-low; bit i low selects position i
seg_in  input  7  segment lines, active-low, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
digits_out  output  4*NUM_DIGITS  recovered nibble per position; position i at bits [4i+3:4i]
digit_valid  output  NUM_DIGITS  last capture at position i was a legal hex pattern
digit_blank  output  NUM_DIGITS  last capture at position i was 7'b1111111 (all segments off)
update_pulse  output  1  one-cycle strobe on every capture
update_index  output  3  position captured; valid only while update_pulse=1
pattern_err  output  1  one-cycle strobe when the captured pattern is neither legal nor blank
frame_done  output  1  one-cycle strobe when every position has been captured since reset or since the last frame_done

Behaviour:
- Legal map, seg_in to nibble:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0001100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F
- Input stage: an_in and seg_in are registered into a sample pair every cycle. No other synchronization is applied; the bus is on-chip.
- The sample pair is a valid select only when exactly one an bit is 0. All-ones or multiple zeros is invalid: it is not an error, and it forces state IDLE with the counter at 0.
- FSM states:
  - IDLE: valid select goes to COUNT with cnt=1.
  - COUNT: pair equal to the previous sample gives cnt+1. A changed pair that is still a valid select restarts with cnt=1 and stays in COUNT. An invalid select goes to IDLE.
  - COUNT to HELD: on the edge where cnt would reach STABLE_CYCLES, the block captures and moves to HELD.
  - HELD: no recapture while the pair is unchanged. A change to another valid select goes to COUNT with cnt=1; an invalid select goes to IDLE.
- Capture at position i, all outputs registered on the capture edge:
  - Legal pattern: nibble written to digits_out slice i, digit_valid[i]=1, digit_blank[i]=0.
  - Blank pattern: digit_blank[i]=1, digit_valid[i]=0, nibble slice holds its previous value.
  - Any other pattern: digit_valid[i]=0, digit_blank[i]=0, nibble holds, pattern_err=1 for that cycle.
  - In all three cases: update_pulse=1, update_index=i, and capture-mask bit i is set.
- Latency: input held constant from edge k is sampled at edge k. Capture outputs are visible after edge k+STABLE_CYCLES-1, i.e. STABLE_CYCLES edges after first presentation.
- Frame completion: when the capture completes the mask (all NUM_DIGITS bits set, counting the current one), frame_done=1 in the same cycle as that update_pulse, and the mask clears to 0. Recapturing an already-set position does not clear the mask or advance it.
- Strobes (update_pulse, pattern_err, frame_done) are high for exactly one cycle per event.
- Reset, including mid-count:
  - Cleared to 0: all outputs, digits_out, digit_valid, digit_blank, the mask, cnt, and the sample registers.
  - Sample an register loads all-ones. State is IDLE. Any partial count is discarded.
- update_index is zero-extended when NUM_DIGITS<8.

Test Plan:
- Reset then hold an_in=1110, seg_in=0010010 for 6 cycles -> one update_pulse after the 4th sampling edge, index=0, digits_out[3:0]=2, digit_valid=0001, no further pulses.
- an_in=1101, seg_in=0000110 held 3 cycles, then seg_in=0111000 held 4 cycles -> no capture for the first pattern; a single capture of F at position 1.
- an_in=1011, seg_in=1111111 held 4 cycles -> digit_blank[2]=1, digit_valid[2]=0, nibble unchanged. Then seg_in=1111110 held 4 cycles -> pattern_err pulse, digit_blank[2]=0.
- an_in=1100 or 1111 with any seg_in held 10 cycles -> no update_pulse and no pattern_err.
- Scan positions 0..3 with 1,9,A,D, each held 5 cycles -> four update_pulses, frame_done coincident with the index-3 pulse, digits_out=16'hDA91, mask cleared. Repeating position 0 alone afterwards -> no frame_done.
- Assert rst with cnt=3 mid-count, release, keep the same pattern -> no capture until 4 fresh stable samples; all outputs read 0 during reset.
